// File: rtl/seven_segment_n.sv
// Multiplexed N-digit seven-segment driver: per-digit enables, leading-zero
// suppression, 16-level PWM brightness and a frame-done strobe.
module seven_segment_n #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned REFRESH_RATE  = 200,
  parameter int unsigned NUM_DIGITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int unsigned DWELL_CYCLES = CLK_FREQUENCY / (REFRESH_RATE * NUM_DIGITS);
  localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  if (DWELL_CYCLES < 16) begin : g_dwell_chk
    $error("seven_segment_n: DWELL_CYCLES must be at least 16");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_digits_chk
    $error("seven_segment_n: NUM_DIGITS must be in 1..16");
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [DW-1:0]           dwell_q, dwell_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_data_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_en_q;
  logic                    sh_lz_q;
  logic [3:0]              sh_br_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q;

  logic                    dwell_wrap, frame_wrap, in_window;
  logic [31:0]             on_cycles;
  logic [NUM_DIGITS-1:0]   supp;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_en, cur_supp;

  always_comb begin
    dwell_wrap = (dwell_q == DWELL_LAST);
    frame_wrap = dwell_wrap && (idx_q == IDX_LAST);
    dwell_d    = dwell_wrap ? '0 : dwell_q + 1'b1;
    idx_d      = idx_q;
    if (dwell_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    on_cycles = ((DWELL_CYCLES - 1) * (32'(sh_br_q) + 32'd1) + 32'd15) / 32'd16;
    // dwell_cnt == 0 is the dark guard slot between digits
    in_window = (dwell_q != '0) && (32'(dwell_q) <= on_cycles);
  end

  // Walk from the top digit down; a digit is suppressible while every nibble
  // from it upward is zero.
  always_comb begin : p_lz
    logic run;
    run  = 1'b1;
    supp = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      run = run && (sh_data_q[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      supp[NUM_DIGITS-1-j] = sh_lz_q && run && (j != NUM_DIGITS - 1);
    end
  end

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_en   = 1'b0;
    cur_supp = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib  = sh_data_q[4*k +: 4];
        cur_dp   = sh_dp_q[k];
        cur_en   = sh_en_q[k];
        cur_supp = supp[k];
      end
    end
    seg_d = 8'hFF;
    an_d  = '1;
    if (in_window && !blank && cur_en && !(cur_supp && !cur_dp)) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = cur_supp ? 8'h7F : {~cur_dp, hex7(cur_nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
      fd_q    <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fd_q    <= frame_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_wrap) begin
      sh_data_q <= data_in;
      sh_dp_q   <= dp_in;
      sh_en_q   <= digit_en;
      sh_lz_q   <= lz_suppress;
      sh_br_q   <= brightness;
    end
  end

  assign segment    = seg_q;
  assign anode      = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_n.sv
// Bench for seven_segment_n: frame-position reference model checked every
// cycle, plus a table of static displays and hand-written corner sequences.
module tb_seven_segment_n;

  localparam int unsigned N     = 8;
  localparam int unsigned DWELL = 16;
  localparam int unsigned FRAME = N * DWELL;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = 32'hfedcba98;
  logic [7:0]  dp_in = 8'hFF;
  logic [7:0]  digit_en = 8'hFF;
  logic        blank = 1'b0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic [7:0]  segment;
  logic [7:0]  anode;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_segment_n #(
    .CLK_FREQUENCY(100_000_000),
    .REFRESH_RATE (781_250),
    .NUM_DIGITS   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blank      (blank),
    .lz_suppress(lz_suppress),
    .brightness (brightness),
    .segment    (segment),
    .anode      (anode),
    .frame_done (frame_done)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position plus a snapshot of the inputs
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        lz;
    logic [3:0]  br;
  } snap_t;

  int unsigned m_pos = 0;
  snap_t       m_snap;
  logic [7:0]  m_seg = 8'hFF;
  logic [7:0]  m_an  = 8'hFF;
  logic        m_fd  = 1'b0;

  function automatic void expect_pins(input int unsigned pos, input snap_t s, input logic blk,
                                      output logic [7:0] seg, output logic [7:0] an);
    int unsigned dig, dw, on;
    logic [3:0]  nib;
    bit          sup;
    dig = pos / DWELL;
    dw  = pos % DWELL;
    on  = ((DWELL - 1) * (32'(s.br) + 1) + 15) / 16;
    nib = 4'((s.data >> (4 * dig)) & 32'hF);
    sup = s.lz && (dig != 0) && ((s.data >> (4 * dig)) == 0);
    seg = 8'hFF;
    an  = 8'hFF;
    if (!blk && dw >= 1 && dw <= on && s.en[dig] && !(sup && !s.dp[dig])) begin
      an  = ~(8'd1 << dig);
      seg = sup ? 8'h7F : {~s.dp[dig], HEX[nib]};
    end
  endfunction

  task automatic model_step();
    snap_t cur;
    cur = '{data: data_in, dp: dp_in, en: digit_en, lz: lz_suppress, br: brightness};
    if (rst) begin
      m_pos  = 0;
      m_snap = cur;
      m_seg  = 8'hFF;
      m_an   = 8'hFF;
      m_fd   = 1'b0;
    end else begin
      expect_pins(m_pos, m_snap, blank, m_seg, m_an);
      m_fd = (m_pos == FRAME - 1);
      if (m_fd) m_snap = cur;
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model_segment", segment, m_seg);
      check("model_anode", anode, m_an);
      check("model_frame_done", frame_done, m_fd);
    end
  end

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME + 4 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    check("frame_done_seen", seen, 1);
  endtask

  logic [7:0]  meas_seg [N];
  int unsigned meas_lit [N];

  task automatic measure_frame();
    for (int k = 0; k < N; k++) begin
      meas_seg[k] = 8'hFF;
      meas_lit[k] = 0;
    end
    repeat (FRAME) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (anode[k] == 1'b0) begin
          meas_lit[k]++;
          meas_seg[k] = segment;
        end
      end
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        lz;
    logic [3:0]  br;
    int unsigned dig;
    logic [7:0]  seg;
    int unsigned lit;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit          found;
    int unsigned cnt;
    logic [31:0] newdata;
    logic [3:0]  nib;

    vecs[0]  = '{32'hfedcba98, 8'hFF, 8'hFF, 1'b0, 4'd15, 0, 8'h00, 15};
    vecs[1]  = '{32'hfedcba98, 8'hFF, 8'hFF, 1'b0, 4'd15, 7, 8'h0E, 15};
    vecs[2]  = '{32'hfedcba98, 8'h00, 8'hFF, 1'b0, 4'd0,  3, 8'h83, 1};
    vecs[3]  = '{32'hfedcba98, 8'h00, 8'hFF, 1'b0, 4'd7,  5, 8'hA1, 8};
    vecs[4]  = '{32'h00000120, 8'h00, 8'hFF, 1'b1, 4'd15, 0, 8'hC0, 15};
    vecs[5]  = '{32'h00000120, 8'h00, 8'hFF, 1'b1, 4'd15, 4, 8'hFF, 0};
    vecs[6]  = '{32'h00000120, 8'h00, 8'hFF, 1'b1, 4'd15, 1, 8'hA4, 15};
    vecs[7]  = '{32'h00000120, 8'h00, 8'hFF, 1'b1, 4'd15, 2, 8'hF9, 15};
    vecs[8]  = '{32'h00000120, 8'h10, 8'hFF, 1'b1, 4'd15, 4, 8'h7F, 15};
    vecs[9]  = '{32'hfedcba98, 8'hFF, 8'h0F, 1'b0, 4'd15, 6, 8'hFF, 0};
    vecs[10] = '{32'hfedcba98, 8'hFF, 8'h0F, 1'b0, 4'd15, 2, 8'h08, 15};
    vecs[11] = '{32'h00000000, 8'h00, 8'hFF, 1'b1, 4'd15, 0, 8'hC0, 15};

    // Reset state and immediate first frame
    repeat (3) @(negedge clk);
    check("rst_segment", segment, 8'hFF);
    check("rst_anode", anode, 8'hFF);
    check("rst_frame_done", frame_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("guard_anode", anode, 8'hFF);
    @(negedge clk);
    check("first_anode", anode, 8'hFE);
    check("first_segment", segment, 8'h00);

    // Static display table
    for (int v = 0; v < 12; v++) begin
      data_in     = vecs[v].data;
      dp_in       = vecs[v].dp;
      digit_en    = vecs[v].en;
      lz_suppress = vecs[v].lz;
      brightness  = vecs[v].br;
      wait_frame();
      measure_frame();
      check($sformatf("vec%0d_lit", v), meas_lit[vecs[v].dig], vecs[v].lit);
      check($sformatf("vec%0d_seg", v), meas_seg[vecs[v].dig], vecs[v].seg);
    end

    // Mid-frame data change is held off until the next frame
    data_in = 32'hfedcba98; dp_in = 8'hFF; digit_en = 8'hFF; lz_suppress = 1'b0; brightness = 4'd15;
    wait_frame();
    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      @(negedge clk);
      found = (anode[3] == 1'b0);
    end
    check("digit3_lit", found, 1);
    newdata = 32'hdeadbeef;
    data_in = newdata;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (anode[7] == 1'b0) check("old_digit7", segment, 8'h0E);
      found = frame_done;
    end
    check("reload_seen", found, 1);
    measure_frame();
    for (int k = 0; k < N; k++) begin
      nib = newdata[4*k +: 4];
      check($sformatf("new_digit%0d", k), meas_seg[k], {1'b0, HEX[nib]});
    end

    // Blank mid-dwell
    found = 1'b0;
    for (int i = 0; i < DWELL && !found; i++) begin
      @(negedge clk);
      found = (anode != 8'hFF);
    end
    check("lit_before_blank", found, 1);
    blank = 1'b1;
    @(negedge clk);
    check("blank_anode", anode, 8'hFF);
    check("blank_segment", segment, 8'hFF);
    cnt = 0;
    repeat (23) begin
      @(negedge clk);
      if (anode != 8'hFF || segment != 8'hFF) cnt++;
    end
    check("blank_dark_cycles", cnt, 0);
    blank = 1'b0;
    repeat (2 * DWELL) @(negedge clk);

    // Random traffic against the model, including mid-frame resets
    repeat (3000) begin
      int unsigned r;
      @(negedge clk);
      r = $urandom_range(0, 999);
      if (r < 25) begin
        data_in     = $urandom >> $urandom_range(0, 31);
        dp_in       = 8'($urandom);
        digit_en    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
        lz_suppress = 1'($urandom);
        brightness  = 4'($urandom);
      end else if (r < 45) begin
        blank = ~blank;
      end else if (r < 48) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
